// File: rtl/aes_comp_dec_sched_pkg.sv
// Shared types for the two-requester AES decipher scheduler.
package aes_comp_dec_sched_pkg;

    localparam int unsigned BLOCK_W = 128;

    // Scheduler FSM encodings
    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_START = 2'd1,
        SCHED_BUSY  = 2'd2,
        SCHED_RESP  = 2'd3
    } sched_state_e;

    // Job held for the core while it runs
    typedef struct packed {
        logic               keylen;
        logic [BLOCK_W-1:0] block;
    } aes_job_t;

endpackage

// File: rtl/aes_comp_rr_arb2.sv
// Two-way round-robin grant; the rr_last flop lives in the parent.
module aes_comp_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    output logic [1:0] grant_c
);

    // One-hot grant: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_c = 2'b00;
        case (valid)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = rr_last ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_comp_dec_sched.sv
// Shares one AES decipher core between two requesters, one job in flight.
// Optional per-requester completion counters: AES_COMP_DEC_SCHED_STATS_EN.
module aes_comp_dec_sched
    import aes_comp_dec_sched_pkg::*;
#(
    parameter int unsigned STATS_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [BLOCK_W-1:0]  req0_block,
    input  logic                req0_keylen,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [BLOCK_W-1:0]  req1_block,
    input  logic                req1_keylen,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [BLOCK_W-1:0]  rsp_block,
    output logic                core_next,
    output logic                core_keylen,
    output logic [BLOCK_W-1:0]  core_block,
    input  logic                core_ready,
    input  logic [BLOCK_W-1:0]  core_new_block,
    output logic                key_id,
    output logic [STATS_W-1:0]  stat0_cnt,
    output logic [STATS_W-1:0]  stat1_cnt
);

    sched_state_e state_q, state_d;
    aes_job_t     job_q, new_job_c;
    logic         rr_last_q;
    logic [1:0]   grant_c;
    logic [1:0]   req_ready_d;
    logic         core_next_d, rsp_valid_d;
    logic         acc0_c, acc1_c, accept_c, rsp_hs_c;

    aes_comp_rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .rr_last (rr_last_q),
        .grant_c (grant_c)
    );

    assign acc0_c   = req0_valid & req0_ready;
    assign acc1_c   = req1_valid & req1_ready;
    assign accept_c = (state_q == SCHED_IDLE) & (acc0_c | acc1_c);
    assign rsp_hs_c = rsp_valid & rsp_ready;

    assign core_block  = job_q.block;
    assign core_keylen = job_q.keylen;

    // Select the payload of whichever requester is handshaking
    always_comb begin
        new_job_c = '0;
        if (acc1_c) begin
            new_job_c.keylen = req1_keylen;
            new_job_c.block  = req1_block;
        end else begin
            new_job_c.keylen = req0_keylen;
            new_job_c.block  = req0_block;
        end
    end

    // Next state and next values of the registered control outputs
    always_comb begin
        state_d     = state_q;
        req_ready_d = 2'b00;
        core_next_d = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            SCHED_IDLE:  if (accept_c)   state_d = SCHED_START;
            SCHED_START:                 state_d = SCHED_BUSY;
            SCHED_BUSY:  if (core_ready) state_d = SCHED_RESP;
            SCHED_RESP:  if (rsp_hs_c)   state_d = SCHED_IDLE;
            default:                     state_d = SCHED_IDLE;
        endcase
        req_ready_d = (state_d == SCHED_IDLE) ? grant_c : 2'b00;
        core_next_d = (state_d == SCHED_START);
        rsp_valid_d = (state_d == SCHED_RESP);
    end

    // State, arbitration history, held job and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SCHED_IDLE;
            rr_last_q  <= 1'b1;
            job_q      <= '0;
            key_id     <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            core_next  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_block  <= '0;
        end else begin
            state_q    <= state_d;
            req0_ready <= req_ready_d[0];
            req1_ready <= req_ready_d[1];
            core_next  <= core_next_d;
            rsp_valid  <= rsp_valid_d;
            if (accept_c) begin
                rr_last_q <= acc1_c;
                job_q     <= new_job_c;
                key_id    <= acc1_c;
            end
            if ((state_q == SCHED_BUSY) && core_ready) begin
                rsp_block <= core_new_block;
                rsp_id    <= key_id;
            end
        end
    end

`ifdef AES_COMP_DEC_SCHED_STATS_EN
    // Completion counters, bumped on each response handshake, wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat0_cnt <= '0;
            stat1_cnt <= '0;
        end else if (rsp_hs_c) begin
            if (rsp_id) stat1_cnt <= stat1_cnt + STATS_W'(1);
            else        stat0_cnt <= stat0_cnt + STATS_W'(1);
        end
    end
`else
    assign stat0_cnt = '0;
    assign stat1_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_comp_dec_sched.sv
// Scoreboard bench for aes_comp_dec_sched with a behavioural decipher core.
module tb_aes_comp_dec_sched;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_COMP_DEC_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         r0_valid = 1'b0, r1_valid = 1'b0;
    logic [127:0] r0_block = '0, r1_block = '0;
    logic         r0_keylen = 1'b0, r1_keylen = 1'b0;
    logic         rsp_rdy = 1'b1;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, core_next, core_keylen, key_id;
    logic [127:0] rsp_block, core_block;
    logic         core_ready;
    logic [127:0] core_new_block;
    logic [15:0]  stat0_cnt, stat1_cnt;

    aes_comp_dec_sched #(.STATS_W(16)) dut (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(r0_valid), .req0_ready(req0_ready), .req0_block(r0_block), .req0_keylen(r0_keylen),
        .req1_valid(r1_valid), .req1_ready(req1_ready), .req1_block(r1_block), .req1_keylen(r1_keylen),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id), .rsp_block(rsp_block),
        .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block),
        .core_ready(core_ready), .core_new_block(core_new_block),
        .key_id(key_id), .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Decipher model: FIPS-197 pairs decrypt when the right key schedule is selected.
    function automatic logic [127:0] model_pt(logic [127:0] blk, logic kl, logic kid);
        if (!kl && !kid && blk == CT128) return PT;
        if (kl && kid && blk == CT256) return PT;
        return blk ^ {32{kid, kl, 2'b10}};
    endfunction

    // Core: ready drops on the edge after next, result after 52 / 72 cycles
    int           core_cnt;
    logic [127:0] core_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready     <= 1'b1;
            core_cnt       <= 0;
            core_new_block <= '0;
            core_pend      <= '0;
        end else if (core_next) begin
            core_ready <= 1'b0;
            core_cnt   <= core_keylen ? 72 : 52;
            core_pend  <= model_pt(core_block, core_keylen, key_id);
        end else if (core_cnt != 0) begin
            if (core_cnt == 1) begin
                core_ready     <= 1'b1;
                core_new_block <= core_pend;
            end
            core_cnt <= core_cnt - 1;
        end
    end

    typedef struct {
        logic         id;
        logic [127:0] blk;
        int           lat;
    } exp_t;
    exp_t sb[$];
    int   exp_stat0 = 0, exp_stat1 = 0;

    // Monitor: latency at rsp_valid rise, payload and key owner on handshake
    int   acc_cyc = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if ((r0_valid && req0_ready) || (r1_valid && req1_ready)) acc_cyc = cyc + 1;
            if (rsp_valid && !prev_v && sb.size() > 0)
                chk("latency", 128'(cyc - acc_cyc), 128'(sb[0].lat));
            if (rsp_valid && rsp_rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 128'(rsp_valid), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 128'(rsp_id), 128'(e.id));
                    chk("rsp_block", rsp_block, e.blk);
                    chk("key_id", 128'(key_id), 128'(e.id));
                    if (e.id) exp_stat1++;
                    else      exp_stat0++;
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic drive(input logic id, input logic [127:0] blk, input logic kl);
        if (id) begin r1_valid = 1'b1; r1_block = blk; r1_keylen = kl; end
        else    begin r0_valid = 1'b1; r0_block = blk; r0_keylen = kl; end
    endtask

    function automatic void push_exp(logic id, logic [127:0] blk, logic kl);
        exp_t e;
        e.id  = id;
        e.blk = model_pt(blk, kl, id);
        e.lat = kl ? 74 : 54;
        sb.push_back(e);
    endfunction

    task automatic start_req(input logic id, input logic [127:0] blk, input logic kl);
        push_exp(id, blk, kl);
        drive(id, blk, kl);
    endtask

    task automatic wait_acc(input logic id);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = id ? (r1_valid && req1_ready) : (r0_valid && req0_ready);
        end
        chk("accept_timeout", 128'(ok), 128'(1));
        @(posedge clk); #1;
        if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (sb.size() != 0 && i < 3000) begin @(negedge clk); i++; end
        chk("drain_timeout", 128'(sb.size()), 128'(0));
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 128'({req1_ready, req0_ready}), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_block", rsp_block, 128'(0));
        chk("rst_core_next", 128'(core_next), 128'(0));
        chk("rst_core_keylen", 128'(core_keylen), 128'(0));
        chk("rst_core_block", core_block, 128'(0));
        chk("rst_key_id", 128'(key_id), 128'(0));
        chk("rst_stats", 128'({stat1_cnt, stat0_cnt}), 128'(0));
    endtask

    task automatic check_stats(string name);
        chk(name, 128'({stat1_cnt, stat0_cnt}),
            STATS ? 128'({16'(exp_stat1), 16'(exp_stat0)}) : 128'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        r0_valid = 1'b0; r1_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_stat0 = 0; exp_stat1 = 0;
    endtask

    initial begin
        logic [127:0] hold_blk;
        logic         hold_id;
        int           n0, n1;
        bit           a0, a1;

        // Reset state
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // FIPS-197 AES-128 on requester 0, then AES-256 on requester 1
        start_req(1'b0, CT128, 1'b0);
        wait_acc(1'b0);
        drain();
        check_stats("stats_after_t1");
        start_req(1'b1, CT256, 1'b1);
        wait_acc(1'b1);
        drain();
        check_stats("stats_after_t2");

        // Both requesters valid from reset: grants alternate 0,1,0,1
        pulse_reset();
        push_exp(1'b0, 128'hA0A0_0000_1111_2222_3333_4444_5555_6666, 1'b0);
        push_exp(1'b1, 128'hB0B0_7777_8888_9999_AAAA_BBBB_CCCC_DDDD, 1'b1);
        push_exp(1'b0, 128'hA1A1_0123_4567_89AB_CDEF_FEDC_BA98_7654, 1'b0);
        push_exp(1'b1, 128'hB1B1_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC, 1'b1);
        drive(1'b0, 128'hA0A0_0000_1111_2222_3333_4444_5555_6666, 1'b0);
        drive(1'b1, 128'hB0B0_7777_8888_9999_AAAA_BBBB_CCCC_DDDD, 1'b1);
        n0 = 0; n1 = 0;
        for (int c = 0; c < 2000 && (n0 < 2 || n1 < 2); c++) begin
            @(negedge clk);
            a0 = r0_valid && req0_ready;
            a1 = r1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) begin
                n0++;
                if (n0 < 2) drive(1'b0, 128'hA1A1_0123_4567_89AB_CDEF_FEDC_BA98_7654, 1'b0);
                else        r0_valid = 1'b0;
            end
            if (a1) begin
                n1++;
                if (n1 < 2) drive(1'b1, 128'hB1B1_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC, 1'b1);
                else        r1_valid = 1'b0;
            end
        end
        chk("arb_accepts", 128'({16'(n0), 16'(n1)}), 128'({16'd2, 16'd2}));
        drain();

        // Back-pressure: response held 20 cycles while requester 1 waits
        rsp_rdy = 1'b0;
        start_req(1'b0, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1'b0);
        wait_acc(1'b0);
        begin
            int i = 0;
            while (!rsp_valid && i < 200) begin @(negedge clk); i++; end
        end
        chk("hold_rsp_valid", 128'(rsp_valid), 128'(1));
        hold_blk = rsp_block;
        hold_id  = rsp_id;
        @(posedge clk); #1;
        start_req(1'b1, 128'h5555_AAAA_5555_AAAA_0000_FFFF_0000_FFFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_block", rsp_block, hold_blk);
            chk("hold_ctrl", 128'({rsp_valid, rsp_id, req1_ready, req0_ready, core_next}),
                128'({1'b1, hold_id, 1'b0, 1'b0, 1'b0}));
        end
        @(posedge clk); #1;
        rsp_rdy = 1'b1;
        wait_acc(1'b1);
        drain();

        // Reset 30 cycles into a job, then a fresh job completes
        start_req(1'b0, CT128, 1'b0);
        wait_acc(1'b0);
        repeat (29) @(posedge clk);
        pulse_reset();
        start_req(1'b0, CT128, 1'b0);
        wait_acc(1'b0);
        drain();

        // Counters: 3 requester-0 and 2 requester-1 completions since reset
        start_req(1'b1, CT256, 1'b1);
        wait_acc(1'b1);
        start_req(1'b0, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 1'b1);
        wait_acc(1'b0);
        start_req(1'b1, 128'hFFFF_0000_FFFF_0000_1234_1234_1234_1234, 1'b0);
        wait_acc(1'b1);
        start_req(1'b0, CT128, 1'b0);
        wait_acc(1'b0);
        drain();
        chk("stat0_final", 128'(stat0_cnt), STATS ? 128'(3) : 128'(0));
        chk("stat1_final", 128'(stat1_cnt), STATS ? 128'(2) : 128'(0));
        check_stats("stats_model");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
